// File: rtl/layer_featuremap_serializer.sv
// layer_featuremap_serializer
// Drains one wide per-pixel channel vector (NUM_CH words, channel 0 in the
// LSBs) and replays it as a DATA_WIDTH-bit stream, one channel per beat,
// with ready/valid flow control on both sides.
// Optional feature macro: FRAME_LAST_EN -- counts pixels and flags the final
// word of each IMG_SIZE x IMG_SIZE frame on last_out.
module layer_featuremap_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 32,
  parameter int IMG_SIZE   = 104,
  localparam int CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  input  logic                         valid_in,
  output logic                         ready_in,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         valid_out,
  input  logic                         ready_out,
  output logic [CW-1:0]                ch_out,
  output logic                         last_out
);

  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } state_t;

  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

  state_t                         state;
  logic [NUM_CH*DATA_WIDTH-1:0]   hold;
  logic [CW-1:0]                  ch_cnt;
  logic [DATA_WIDTH-1:0]          words [NUM_CH];
  logic                           at_last_ch;
  logic                           out_xfer;

  // Split the holding register into per-channel words for the output mux.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_words
    assign words[k] = hold[k*DATA_WIDTH +: DATA_WIDTH];
  end

  assign at_last_ch = (ch_cnt == LAST_CH);
  assign valid_out  = (state == SEND);
  assign out_xfer   = valid_out && ready_out;
  assign ch_out     = ch_cnt;
  assign data_out   = (state == SEND) ? words[ch_cnt] : '0;

  // We can take a new vector when idle, or on the very beat that drains the
  // last channel, which is what gives back-to-back vectors no bubble.
  assign ready_in = (state == EMPTY) || (state == SEND && at_last_ch && ready_out);

  // Main sequencer: capture a vector, then walk the channel index per beat.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state  <= EMPTY;
      hold   <= '0;
      ch_cnt <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (valid_in) begin
            hold   <= data_in;
            ch_cnt <= '0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (ready_out) begin
            if (!at_last_ch) begin
              ch_cnt <= ch_cnt + CW'(1);
            end else if (valid_in) begin
              hold   <= data_in;
              ch_cnt <= '0;
            end else begin
              ch_cnt <= '0;
              state  <= EMPTY;
            end
          end
        end
        default: begin
          state  <= EMPTY;
          ch_cnt <= '0;
        end
      endcase
    end
  end

`ifdef FRAME_LAST_EN
  localparam int PIXELS = IMG_SIZE * IMG_SIZE;
  localparam int PW     = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam logic [PW-1:0] LAST_PIX = PW'(PIXELS - 1);

  logic [PW-1:0] pix_cnt;

  // Count completed pixels (vectors) and wrap at the end of each frame.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pix_cnt <= '0;
    end else if (out_xfer && at_last_ch) begin
      pix_cnt <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + PW'(1);
    end
  end

  assign last_out = valid_out && at_last_ch && (pix_cnt == LAST_PIX);
`else
  assign last_out = 1'b0;
`endif

endmodule

// File: tb/tb_layer_featuremap_serializer.sv
// Testbench for layer_featuremap_serializer.
// A queue-based reference model expands each accepted vector into its
// expected beats; a monitor compares every cycle, and directed sequences add
// hand-computed literal expectations.
module tb_layer_featuremap_serializer;

  localparam int DW  = 32;
  localparam int NCH = 32;
  localparam int IMG = 2;
  localparam int CW  = $clog2(NCH);

  logic                 Clk;
  logic                 Rst;
  logic [NCH*DW-1:0]    data_in;
  logic                 valid_in;
  logic                 ready_in;
  logic [DW-1:0]        data_out;
  logic                 valid_out;
  logic                 ready_out;
  logic [CW-1:0]        ch_out;
  logic                 last_out;

  layer_featuremap_serializer #(
    .DATA_WIDTH(DW),
    .NUM_CH    (NCH),
    .IMG_SIZE  (IMG)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_in (ready_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .ready_out(ready_out),
    .ch_out   (ch_out),
    .last_out (last_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [DW-1:0] data;
    int            ch;
    logic          last;
  } beat_t;

  beat_t        expq[$];
  int           vecs_since_reset;
  int           checks;
  int           failures;
  int           beats;
  int           valid_cycles;
  int           ready_pulses;
  int           last_count;
  int           last_beat;
  logic [DW-1:0] last_data;

  // Literal and model comparisons share one reporting path.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearStats();
    beats        = 0;
    valid_cycles = 0;
    ready_pulses = 0;
    last_count   = 0;
    last_beat    = -1;
    last_data    = '0;
  endtask

  task automatic setVector(input logic [DW-1:0] base);
    for (int k = 0; k < NCH; k++) data_in[k*DW +: DW] = base + DW'(k);
  endtask

  // Present n vectors back to back (valid_in held), vector v = base + v*0x100 + k.
  task automatic applyStimulus(input int n, input logic [DW-1:0] base);
    for (int v = 0; v < n; v++) begin
      int t;
      setVector(base + DW'(v) * 32'h100);
      valid_in = 1'b1;
      t = 0;
      forever begin
        @(negedge Clk);
        if (ready_in) break;
        t++;
        if (t > 300) begin
          checkOutput("accept_timeout", 64'd0, 64'd1);
          break;
        end
      end
      @(posedge Clk);
      #1;
    end
    valid_in = 1'b0;
  endtask

  task automatic waitCh(input int ch);
    int t;
    t = 0;
    forever begin
      @(negedge Clk);
      if (valid_out && int'(ch_out) == ch) break;
      t++;
      if (t > 300) begin
        checkOutput("wait_ch_timeout", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  task automatic waitIdle();
    int t;
    t = 0;
    forever begin
      @(negedge Clk);
      if (!valid_out) break;
      t++;
      if (t > 400) begin
        checkOutput("wait_idle_timeout", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  // Reference model and per-cycle comparison, sampled mid-cycle.
  always @(negedge Clk) begin
    if (!Rst) begin
      expq.delete();
      vecs_since_reset = 0;
    end else begin
      logic exp_ready;
      checkOutput("valid_out", 64'(valid_out), 64'(expq.size() != 0));
      exp_ready = (expq.size() == 0) || (expq[0].ch == NCH - 1 && ready_out);
      checkOutput("ready_in", 64'(ready_in), 64'(exp_ready));
      if (valid_out && expq.size() != 0) begin
        checkOutput("data_out", 64'(data_out), 64'(expq[0].data));
        checkOutput("ch_out", 64'(ch_out), 64'(expq[0].ch));
        checkOutput("last_out", 64'(last_out), 64'(expq[0].last));
      end
      if (valid_out) valid_cycles++;
      if (valid_out && ready_in) ready_pulses++;
      if (valid_out && ready_out) begin
        beats++;
        last_data = data_out;
        if (last_out) begin
          last_count++;
          last_beat = beats;
        end
        if (expq.size() != 0) void'(expq.pop_front());
      end
      if (valid_in && ready_in) begin
        for (int k = 0; k < NCH; k++) begin
          beat_t b;
          b.data = data_in[k*DW +: DW];
          b.ch   = k;
`ifdef FRAME_LAST_EN
          b.last = (k == NCH - 1) && ((vecs_since_reset % (IMG*IMG)) == IMG*IMG - 1);
`else
          b.last = 1'b0;
`endif
          expq.push_back(b);
        end
        vecs_since_reset++;
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    clearStats();
    Rst       = 1'b0;
    valid_in  = 1'b0;
    data_in   = '0;
    ready_out = 1'b1;

    // Reset state, before any clock edge.
    #3;
    checkOutput("rst_valid_out", 64'(valid_out), 64'd0);
    checkOutput("rst_data_out", 64'(data_out), 64'd0);
    checkOutput("rst_ch_out", 64'(ch_out), 64'd0);
    checkOutput("rst_last_out", 64'(last_out), 64'd0);
    checkOutput("rst_ready_in", 64'(ready_in), 64'd1);
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b1;
    @(posedge Clk);
    #1;

    // Single vector, one-cycle latency, 32 beats then idle.
    clearStats();
    applyStimulus(1, 32'h3F800000);
    checkOutput("t1_first_valid", 64'(valid_out), 64'd1);
    checkOutput("t1_first_ch", 64'(ch_out), 64'd0);
    checkOutput("t1_first_data", 64'(data_out), 64'h3F800000);
    waitIdle();
    checkOutput("t1_beats", 64'(beats), 64'd32);
    checkOutput("t1_last_data", 64'(last_data), 64'h3F80001F);
    checkOutput("t1_idle_ready_in", 64'(ready_in), 64'd1);
    @(posedge Clk);
    #1;

    // Two vectors back to back: 64 gapless beats, ready_in only on ch 31 beats.
    clearStats();
    applyStimulus(2, 32'h41000000);
    waitIdle();
    checkOutput("t2_beats", 64'(beats), 64'd64);
    checkOutput("t2_valid_cycles", 64'(valid_cycles), 64'd64);
    checkOutput("t2_ready_pulses", 64'(ready_pulses), 64'd2);
    checkOutput("t2_last_data", 64'(last_data), 64'h4100011F);
    @(posedge Clk);
    #1;

    // Two-cycle stall on channel 5.
    clearStats();
    applyStimulus(1, 32'h42000000);
    waitCh(4);
    @(posedge Clk);
    #1 ready_out = 1'b0;
    @(negedge Clk);
    checkOutput("t3_stall1_ch", 64'(ch_out), 64'd5);
    checkOutput("t3_stall1_data", 64'(data_out), 64'h42000005);
    @(posedge Clk);
    #1;
    @(negedge Clk);
    checkOutput("t3_stall2_ch", 64'(ch_out), 64'd5);
    checkOutput("t3_stall2_valid", 64'(valid_out), 64'd1);
    @(posedge Clk);
    #1 ready_out = 1'b1;
    waitIdle();
    checkOutput("t3_beats", 64'(beats), 64'd32);
    checkOutput("t3_valid_cycles", 64'(valid_cycles), 64'd34);
    @(posedge Clk);
    #1;

    // Asynchronous reset while channel 12 is showing.
    applyStimulus(1, 32'h43000000);
    waitCh(12);
    #1 Rst = 1'b0;
    #1;
    checkOutput("t4_rst_valid_out", 64'(valid_out), 64'd0);
    checkOutput("t4_rst_ch_out", 64'(ch_out), 64'd0);
    checkOutput("t4_rst_data_out", 64'(data_out), 64'd0);
    @(posedge Clk);
    #1;
    @(posedge Clk);
    #1 Rst = 1'b1;
    clearStats();
    applyStimulus(1, 32'h44000000);
    checkOutput("t4_restart_ch", 64'(ch_out), 64'd0);
    checkOutput("t4_restart_data", 64'(data_out), 64'h44000000);
    waitIdle();
    checkOutput("t4_beats", 64'(beats), 64'd32);
    @(posedge Clk);
    #1;

    // valid_in raised mid-vector must be ignored.
    clearStats();
    applyStimulus(1, 32'h45000000);
    waitCh(2);
    @(posedge Clk);
    #1;
    setVector(32'h4F000000);
    valid_in = 1'b1;
    @(negedge Clk);
    checkOutput("t5_ready_in_busy", 64'(ready_in), 64'd0);
    checkOutput("t5_ch_out", 64'(ch_out), 64'd3);
    @(posedge Clk);
    #1;
    valid_in = 1'b0;
    data_in  = '0;
    @(negedge Clk);
    checkOutput("t5_data_after", 64'(data_out), 64'h45000004);
    waitIdle();
    checkOutput("t5_beats", 64'(beats), 64'd32);
    checkOutput("t5_last_data", 64'(last_data), 64'h4500001F);
    @(posedge Clk);
    #1;

    // Frame-last marker over a 2x2 frame, plus wrap into the next frame.
    Rst = 1'b0;
    @(posedge Clk);
    #1 Rst = 1'b1;
    @(posedge Clk);
    #1;
    clearStats();
`ifdef FRAME_LAST_EN
    applyStimulus(5, 32'h46000000);
    waitIdle();
    checkOutput("t6_beats", 64'(beats), 64'd160);
    checkOutput("t6_last_count", 64'(last_count), 64'd1);
    checkOutput("t6_last_beat", 64'(last_beat), 64'd128);
`else
    applyStimulus(4, 32'h46000000);
    waitIdle();
    checkOutput("t6_beats", 64'(beats), 64'd128);
    checkOutput("t6_last_count", 64'(last_count), 64'd0);
`endif

    repeat (2) @(posedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
